// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types for the write-side arbiter and its neighbours.
package fb_pkg;
    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic {SERVE, CLEAR} arb_state_e;
endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester, clear-control and framebuffer write-port bundle for fb_write_arbiter.
interface fb_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 24,
    parameter int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        REQ_VALID;
    logic [NUM_REQ-1:0]        REQ_READY;
    logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
    logic                      CLEAR_START;
    logic [DATA_W-1:0]         CLEAR_DATA;
    logic                      CLEAR_BUSY;
    logic                      WRITE_EN;
    logic [ADDR_W-1:0]         WRITE_ADDR;
    logic [DATA_W-1:0]         WRITE_DATA;
    logic [GID_W-1:0]          GRANT_ID;
    logic                      OOR_DROP;

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_DATA, CLEAR_START, CLEAR_DATA,
        input  REQ_READY, CLEAR_BUSY, WRITE_EN, WRITE_ADDR, WRITE_DATA, GRANT_ID, OOR_DROP
    );

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, CLEAR_START, CLEAR_DATA,
        output REQ_READY, CLEAR_BUSY, WRITE_EN, WRITE_ADDR, WRITE_DATA, GRANT_ID, OOR_DROP
    );
endinterface

// File: rtl/fb_rr_arbiter.sv
// Combinational round-robin selector: first valid bit at or above the pointer, else wrap to the lowest.
module fb_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);
    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_pick;

    always_comb begin
        w_hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_hi[i] = i_valid[i] && (i >= int'(i_ptr));
        end
        w_pick = (|w_hi) ? w_hi : i_valid;
    end

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin requesters, range drop, optional full-screen clear.
// The clear engine is built only when FB_ARB_CLEAR_EN is defined.
module fb_write_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
    parameter int ADDR_W    = fb_pkg::ADDR_W,
    parameter int DATA_W    = fb_pkg::DATA_W
) (
    input  logic               WRITE_CLK,
    input  logic               RESET,
    fb_write_arbiter_if.slave  bus
);
    import fb_pkg::arb_state_e;
    import fb_pkg::SERVE;
    import fb_pkg::CLEAR;

    localparam int               IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int               PIX    = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PIX - 1);
    localparam logic [ADDR_W:0]   PIX_X = (ADDR_W + 1)'(PIX);

    arb_state_e          r_state, w_next;
    logic [IDX_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_clr_data;
    logic                r_we, r_oor;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [IDX_W-1:0]    r_gid;

    logic [NUM_REQ-1:0]  w_grant, w_ready;
    logic [IDX_W-1:0]    w_idx, w_ptr_nxt;
    logic                w_clr_go, w_xfer, w_in_range;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    fb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_valid (bus.REQ_VALID),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

`ifdef FB_ARB_CLEAR_EN
    assign w_clr_go       = (r_state == SERVE) && bus.CLEAR_START;
    assign bus.CLEAR_BUSY = (r_state == CLEAR);
`else
    // Start pulse is still wired so integration is identical; it never takes effect.
    assign w_clr_go       = bus.CLEAR_START & 1'b0;
    assign bus.CLEAR_BUSY = 1'b0;
`endif

    // A clear start outranks any pending request in the same cycle.
    assign w_ready       = (!RESET && (r_state == SERVE) && !w_clr_go) ? w_grant : '0;
    assign bus.REQ_READY = w_ready;
    assign w_xfer        = |w_ready;
    assign w_ptr_nxt     = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = bus.REQ_ADDR[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
        w_in_range = ({1'b0, w_sel_addr} < PIX_X);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SERVE:   if (w_clr_go) w_next = CLEAR;
            CLEAR:   if (r_cnt == LAST) w_next = SERVE;
            default: w_next = SERVE;
        endcase
    end

    always_ff @(posedge WRITE_CLK) begin
        if (RESET) begin
            r_state    <= SERVE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_clr_data <= '0;
            r_we       <= 1'b0;
            r_oor      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_gid      <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            if (r_state == CLEAR) begin
                r_we   <= 1'b1;
                r_addr <= r_cnt;
                r_data <= r_clr_data;
                r_gid  <= '0;
                r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end else if (w_clr_go) begin
                r_clr_data <= bus.CLEAR_DATA;
                r_cnt      <= '0;
            end else if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
                r_gid <= w_idx;
                // Out-of-range writes still handshake so the requester never stalls.
                if (w_in_range) begin
                    r_we   <= 1'b1;
                    r_addr <= w_sel_addr;
                    r_data <= w_sel_data;
                end else begin
                    r_oor  <= 1'b1;
                end
            end
        end
    end

    assign bus.WRITE_EN   = r_we;
    assign bus.WRITE_ADDR = r_addr;
    assign bus.WRITE_DATA = r_data;
    assign bus.GRANT_ID   = r_gid;
    assign bus.OOR_DROP   = r_oor;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a 640x480 instance for arbitration/range, a 4x2 instance for clear.
module tb_fb_write_arbiter;
    import fb_pkg::*;

    typedef struct packed {
        logic        oor;
        logic [18:0] addr;
        logic [23:0] data;
        logic [1:0]  gid;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(19), .DATA_W(24)) bus_a ();
    fb_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(19), .DATA_W(24)) bus_b ();

    fb_write_arbiter #(.NUM_REQ(3)) dut_a (.WRITE_CLK(clk), .RESET(rst), .bus(bus_a));
    fb_write_arbiter #(.NUM_REQ(3), .FB_WIDTH(4), .FB_HEIGHT(2)) dut_b (.WRITE_CLK(clk), .RESET(rst), .bus(bus_b));

    wr_t         qa[$], qb[$];
    int          checks = 0, errors = 0;
    logic [18:0] aA[3], aB[3];
    logic [23:0] dA[3], dB[3];
    pixel_t      c2 = '{r: 8'h12, g: 8'h34, b: 8'h56};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Pops the write expected from the previous edge (if any) and compares the write port.
    task automatic mon(input string n, input logic we, input logic oor, input logic [18:0] a,
                       input logic [23:0] d, input logic [1:0] g, ref wr_t q[$]);
        wr_t  e;
        logic ev;
        e  = '0;
        ev = (q.size() > 0);
        if (ev) e = q.pop_front();
        chk({n, "_we"},  64'(we),  64'(ev && !e.oor));
        chk({n, "_oor"}, 64'(oor), 64'(ev && e.oor));
        if (ev && !e.oor) begin
            chk({n, "_addr"}, 64'(a), 64'(e.addr));
            chk({n, "_data"}, 64'(d), 64'(e.data));
            chk({n, "_gid"},  64'(g), 64'(e.gid));
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon("a", bus_a.WRITE_EN, bus_a.OOR_DROP, bus_a.WRITE_ADDR, bus_a.WRITE_DATA, bus_a.GRANT_ID, qa);
        mon("b", bus_b.WRITE_EN, bus_b.OOR_DROP, bus_b.WRITE_ADDR, bus_b.WRITE_DATA, bus_b.GRANT_ID, qb);
    endtask

    task automatic xa(input logic [2:0] v, input logic [2:0] er);
        wr_t e;
        bus_a.REQ_VALID = v;
        for (int i = 0; i < 3; i++) begin
            bus_a.REQ_ADDR[i*19 +: 19] = aA[i];
            bus_a.REQ_DATA[i*24 +: 24] = dA[i];
        end
        #1;
        chk("a_ready", 64'(bus_a.REQ_READY), 64'(er));
        for (int i = 0; i < 3; i++) begin
            if (er[i]) begin
                e.oor = (aA[i] >= 19'd307200); e.addr = aA[i]; e.data = dA[i]; e.gid = 2'(i);
                qa.push_back(e);
            end
        end
    endtask

    task automatic xb(input logic [2:0] v, input logic [2:0] er);
        wr_t e;
        bus_b.REQ_VALID = v;
        for (int i = 0; i < 3; i++) begin
            bus_b.REQ_ADDR[i*19 +: 19] = aB[i];
            bus_b.REQ_DATA[i*24 +: 24] = dB[i];
        end
        #1;
        chk("b_ready", 64'(bus_b.REQ_READY), 64'(er));
        for (int i = 0; i < 3; i++) begin
            if (er[i]) begin
                e.oor = (aB[i] >= 19'd8); e.addr = aB[i]; e.data = dB[i]; e.gid = 2'(i);
                qb.push_back(e);
            end
        end
    endtask

    task automatic push_clr(input int j, input logic [23:0] c);
        wr_t e;
        e.oor = 1'b0; e.addr = 19'(j); e.data = c; e.gid = 2'd0;
        qb.push_back(e);
    endtask

    initial begin
        aA = '{19'd100, 19'd200, 19'd300};
        dA = '{24'h111111, 24'h222222, 24'h333333};
        aB = '{19'd1, 19'd2, 19'd3};
        dB = '{24'hA0A0A0, 24'hB0B0B0, 24'hC0C0C0};
        rst = 1'b1;
        bus_a.REQ_VALID = 3'b001; bus_a.REQ_ADDR = '0; bus_a.REQ_DATA = '0;
        bus_a.CLEAR_START = 1'b0; bus_a.CLEAR_DATA = '0;
        bus_b.REQ_VALID = 3'b000; bus_b.REQ_ADDR = '0; bus_b.REQ_DATA = '0;
        bus_b.CLEAR_START = 1'b0; bus_b.CLEAR_DATA = '0;

        // Reset with requester 0 pending
        step();
        chk("rst_ready", 64'(bus_a.REQ_READY), 64'(3'b000));
        chk("rst_addr",  64'(bus_a.WRITE_ADDR), 64'(0));
        chk("rst_data",  64'(bus_a.WRITE_DATA), 64'(0));
        chk("rst_gid",   64'(bus_a.GRANT_ID), 64'(0));
        chk("rst_busy",  64'(bus_a.CLEAR_BUSY), 64'(0));
        rst = 1'b0;
        xa(3'b001, 3'b001);

        // Re-reset so round-robin starts from pointer 0
        step(); rst = 1'b1; xa(3'b000, 3'b000);
        step(); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            xa(3'b111, 3'b001 << (k % 3));
            step();
        end
        // Sole requester may be granted back to back
        xa(3'b001, 3'b001);
        step(); xa(3'b001, 3'b001);

        // Out-of-range drop, last valid address, top of address space
        step(); aA[1] = 19'd307200; dA[1] = 24'h0000AA; xa(3'b010, 3'b010);
        step(); aA[1] = 19'd307199; dA[1] = 24'hFF00FF; xa(3'b010, 3'b010);
        step(); aA[2] = 19'h7FFFF; xa(3'b100, 3'b100);
        step(); xa(3'b000, 3'b000);

`ifdef FB_ARB_CLEAR_EN
        // Clear of a 4x2 buffer while requester 0 keeps asking
        step(); bus_b.CLEAR_START = 1'b1; bus_b.CLEAR_DATA = 24'h000000; xb(3'b001, 3'b000);
        chk("c1_busy_pre", 64'(bus_b.CLEAR_BUSY), 64'(0));
        for (int j = 0; j < 8; j++) begin
            step(); bus_b.CLEAR_START = 1'b0;
            chk("c1_busy", 64'(bus_b.CLEAR_BUSY), 64'(1));
            xb(3'b001, 3'b000); push_clr(j, 24'h000000);
        end
        step(); chk("c1_busy_end", 64'(bus_b.CLEAR_BUSY), 64'(0)); xb(3'b001, 3'b001);

        // Clear beats a simultaneous request; a second start mid-sweep is ignored
        step(); bus_b.CLEAR_START = 1'b1; bus_b.CLEAR_DATA = c2; xb(3'b010, 3'b000);
        for (int j = 0; j < 8; j++) begin
            step(); bus_b.CLEAR_START = (j == 2); bus_b.CLEAR_DATA = 24'hABCDEF;
            chk("c2_busy", 64'(bus_b.CLEAR_BUSY), 64'(1));
            xb(3'b010, 3'b000); push_clr(j, c2);
        end
        step(); bus_b.CLEAR_START = 1'b0;
        chk("c2_busy_end", 64'(bus_b.CLEAR_BUSY), 64'(0)); xb(3'b010, 3'b010);

        // Reset once address 3 has been presented
        step(); bus_b.CLEAR_START = 1'b1; bus_b.CLEAR_DATA = 24'h0F0F0F; xb(3'b000, 3'b000);
        for (int j = 0; j < 4; j++) begin
            step(); bus_b.CLEAR_START = 1'b0; xb(3'b000, 3'b000); push_clr(j, 24'h0F0F0F);
        end
        step(); rst = 1'b1; xb(3'b000, 3'b000);
        step(); chk("c3_busy", 64'(bus_b.CLEAR_BUSY), 64'(0));
        rst = 1'b0; xb(3'b111, 3'b001);
        step(); xb(3'b000, 3'b000);
`else
        // Without the clear engine the start pulse has no effect
        step(); bus_b.CLEAR_START = 1'b1; bus_b.CLEAR_DATA = c2; xb(3'b010, 3'b010);
        step(); bus_b.CLEAR_START = 1'b0;
        chk("nc_busy0", 64'(bus_b.CLEAR_BUSY), 64'(0)); xb(3'b001, 3'b001);
        step(); chk("nc_busy1", 64'(bus_b.CLEAR_BUSY), 64'(0)); xb(3'b000, 3'b000);
        step(); chk("nc_busy2", 64'(bus_b.CLEAR_BUSY), 64'(0)); xb(3'b000, 3'b000);
`endif
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
